// File: rtl/led_tape.sv
// led_tape: WS2812B one-wire NRZ serializer with per-LED host fetch; define LED_TAPE_GRB_EN for G,R,B wire order
module led_tape #(
  parameter int NUM_LEDS       = 7,
  parameter int NUM_RESET_LEDS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] RGB,
  output logic        data,
  output logic [15:0] num,
  output logic        sync,
  output logic        req
);
  localparam int          RST_SLOTS = (NUM_RESET_LEDS < 1) ? 1 : NUM_RESET_LEDS;
  localparam logic [15:0] LAST      = 16'(NUM_LEDS + RST_SLOTS - 1);
  localparam logic [15:0] LEDS      = 16'(NUM_LEDS);
  logic [1:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] num_q, num_d, succ;
  logic [23:0] sr_q, sr_d, word;
  logic        data_q, data_d, sync_q, sync_d, req_q, req_d, end_slot;
`ifdef LED_TAPE_GRB_EN
  assign word = {RGB[15:8], RGB[23:16], RGB[7:0]};
`else
  assign word = RGB;
`endif
  // Outputs are registered from the next-state counters so they describe the clock being entered.
  always_comb begin
    end_slot = phase_q == 2'd2 && bit_q == 5'd0;
    phase_d  = phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
    bit_d    = phase_q != 2'd2 ? bit_q : (bit_q == 5'd0 ? 5'd23 : bit_q - 5'd1);
    num_d    = !end_slot ? num_q : (num_q == LAST ? 16'd0 : num_q + 16'd1);
    succ     = num_d == LAST ? 16'd0 : num_d + 16'd1;
    sr_d     = end_slot ? word : (phase_q == 2'd2 ? {sr_q[22:0], 1'b0} : sr_q);
    sync_d   = num_d >= LEDS;
    data_d   = !sync_d && (phase_d == 2'd0 || (phase_d == 2'd1 && sr_d[23]));
    req_d    = phase_d == 2'd1 && bit_d == 5'd0 && succ < LEDS;
  end
  // State and output registers; reset parks the line in the first latch slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      bit_q   <= 5'd23;
      num_q   <= LEDS;
      sr_q    <= 24'd0;
      data_q  <= 1'b0;
      sync_q  <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
      num_q   <= num_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
    end
  end
  assign data = data_q;
  assign num  = num_q;
  assign sync = sync_q;
  assign req  = req_q;
endmodule

// File: tb/tb_led_tape.sv
// tb_led_tape: host model, pulse-width line decoder with expected-word scoreboard, and directed timing checks
module tb_led_tape;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb = 24'd0;
  logic        data, sync, req;
  logic [15:0] num;
  led_tape dut (.clk(clk), .rst_n(rst_n), .RGB(rgb), .data(data), .num(num), .sync(sync), .req(req));
  always #5 clk = ~clk;
  int          errs = 0, checks = 0, cyc = 0;
  logic [23:0] exp_q[$];
  logic [23:0] wl[$];
  int          req_t[$];
  logic        dh[4096];
  logic        sh[4096];
  logic [15:0] nh[4096];
  logic [7:0]  color = 8'h31;
  logic        prev_s = 1'b1, prev_d = 1'b0;
  int          hi_len = 0, nbits = 0, bad = 0;
  logic [23:0] acc = 24'd0;

  function automatic logic [23:0] wire_word(input logic [7:0] c);
`ifdef LED_TAPE_GRB_EN
    return {8'hB6, 8'hA5, c};
`else
    return {8'hA5, 8'hB6, c};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Host: answers each req with {A5,B6,color}; color steps on every sync rising edge.
  initial forever begin
    @(negedge clk);
    if (sync && !prev_s) color = color + 8'd1;
    prev_s = sync;
    if (rst_n && req) begin
      rgb = {8'hA5, 8'hB6, color};
      exp_q.push_back(wire_word(color));
    end
  end

  // Monitor: records line history and decodes NRZ pulses into words checked against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cyc = 0; hi_len = 0; nbits = 0; prev_d = 1'b0;
      exp_q.delete();
    end else begin
      if (cyc < 4096) begin
        dh[cyc] = data; sh[cyc] = sync; nh[cyc] = num;
      end
      if (req) req_t.push_back(cyc);
      if (data) hi_len++;
      else if (prev_d) begin
        if (hi_len != 1 && hi_len != 2) bad++;
        acc = {acc[22:0], hi_len == 2};
        hi_len = 0;
        nbits++;
        if (nbits == 24) begin
          nbits = 0;
          wl.push_back(acc);
          if (exp_q.size() == 0) begin
            checks++; errs++;
            $display("FAIL word: got %0h want none", acc);
          end else chk("word", 32'(acc), 32'(exp_q.pop_front()));
        end
      end
      prev_d = data;
      cyc++;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 0);
    chk("rst_sync", 32'(sync), 1);
    chk("rst_num", 32'(num), 7);
    chk("rst_req", 32'(req), 0);
    rst_n = 1'b1;
    repeat (3385) @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 720; i++) n += int'(sh[i]);
    chk("latch_sync", 32'(n), 720);
    n = 0;
    for (int i = 0; i < 720; i++) n += int'(dh[i]);
    chk("latch_data", 32'(n), 0);
    chk("first_bits", 32'({dh[720], dh[721], dh[722], dh[723], dh[724], dh[725]}), 32'b110100);
    for (int s = 0; s <= 17; s++) begin
      chk("num_start", 32'(nh[720 + 72 * s]), 32'(s % 17));
      chk("num_prev", 32'(nh[719 + 72 * s]), 32'((s + 16) % 17));
    end
    n = 0;
    for (int i = 720; i < 1944; i++) n += int'(sh[i]);
    chk("frame_sync", 32'(n), 720);
    chk("sync_lo_1223", 32'(sh[1223]), 0);
    chk("sync_rise_1224", 32'(sh[1224]), 1);
    chk("sync_fall_1944", 32'(sh[1944]), 0);
    chk("req_count", 32'(req_t.size()), 18);
    for (int i = 0; i < req_t.size() && i < 18; i++)
      chk("req_time", 32'(req_t[i]), 32'(718 + 1224 * (i / 7) + 72 * (i % 7)));
    chk("words_pre", 32'(wl.size()), 17);
    if (wl.size() >= 17) begin
      chk("word0", 32'(wl[0]), 32'(wire_word(8'h31)));
      chk("word7", 32'(wl[7]), 32'(wire_word(8'h32)));
      chk("word14", 32'(wl[14]), 32'(wire_word(8'h33)));
    end
    chk("pre_rst_data", 32'(data), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_sync", 32'(sync), 1);
    chk("mid_rst_num", 32'(num), 7);
    chk("mid_rst_req", 32'(req), 0);
    req_t.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (1300) @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 720; i++) n += int'(sh[i]);
    chk("relatch_sync", 32'(n), 720);
    n = 0;
    for (int i = 0; i < 720; i++) n += int'(dh[i]);
    chk("relatch_data", 32'(n), 0);
    chk("restart_data", 32'(dh[720]), 1);
    chk("restart_num", 32'(nh[720]), 0);
    chk("restart_req0", 32'(req_t.size() > 0 ? req_t[0] : -1), 718);
    chk("words_post", 32'(wl.size()), 24);
    if (wl.size() >= 18) chk("word_after_rst", 32'(wl[17]), 32'(wire_word(8'h34)));
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("pulse_widths", 32'(bad), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
